// File: rtl/nonmax_suppress_if.sv
// Window-in / suppressed-magnitude-out bundle for the non-maximum suppression stage.
// The master drives windows; the slave (the NMS core) returns one result per window.
interface nonmax_suppress_if #(
   parameter int DATA_WIDTH = 26,
   parameter int MAG_WIDTH  = 24
);
   logic                  frame_start;
   logic                  win_valid;
   logic [DATA_WIDTH-1:0] matrix_p11;
   logic [DATA_WIDTH-1:0] matrix_p12;
   logic [DATA_WIDTH-1:0] matrix_p13;
   logic [DATA_WIDTH-1:0] matrix_p21;
   logic [DATA_WIDTH-1:0] matrix_p22;
   logic [DATA_WIDTH-1:0] matrix_p23;
   logic [DATA_WIDTH-1:0] matrix_p31;
   logic [DATA_WIDTH-1:0] matrix_p32;
   logic [DATA_WIDTH-1:0] matrix_p33;
   logic                  nms_valid;
   logic [MAG_WIDTH-1:0]  nms_mag;
   logic [1:0]            nms_dir;
   logic                  frame_done;

   modport master (
      output frame_start, win_valid,
      output matrix_p11, matrix_p12, matrix_p13,
      output matrix_p21, matrix_p22, matrix_p23,
      output matrix_p31, matrix_p32, matrix_p33,
      input  nms_valid, nms_mag, nms_dir, frame_done
   );

   modport slave (
      input  frame_start, win_valid,
      input  matrix_p11, matrix_p12, matrix_p13,
      input  matrix_p21, matrix_p22, matrix_p23,
      input  matrix_p31, matrix_p32, matrix_p33,
      output nms_valid, nms_mag, nms_dir, frame_done
   );
endinterface

// File: rtl/nonmax_suppress.sv
// Two-stage non-maximum suppression over a 3x3 gradient window with frame-border zeroing.
// Stage 1 picks the neighbour pair along the gradient direction; stage 2 decides keep/zero.
module nonmax_suppress #(
   parameter int WIDTH      = 512,
   parameter int DEPTH      = 512,
   parameter int DATA_WIDTH = 26,
   parameter int MAG_WIDTH  = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   nonmax_suppress_if.slave  bus
);
   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

   // Strict on one side, non-strict on the other, so a plateau keeps exactly one pixel.
   function automatic logic nms_keep(input logic [MAG_WIDTH-1:0] c,
                                     input logic [MAG_WIDTH-1:0] a,
                                     input logic [MAG_WIDTH-1:0] b);
      return (c > a) && (c >= b);
   endfunction

   function automatic logic on_border(input logic [COL_W-1:0] col,
                                      input logic [ROW_W-1:0] row);
      return (col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST);
   endfunction

   logic [1:0]           dir_c;
   logic [MAG_WIDTH-1:0] mag_c;
   logic [MAG_WIDTH-1:0] mag_a;
   logic [MAG_WIDTH-1:0] mag_b;

   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic [COL_W-1:0] col_tag;
   logic [ROW_W-1:0] row_tag;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row_nxt;

   logic                 vld_p1;
   logic [MAG_WIDTH-1:0] mag_c_p1;
   logic [MAG_WIDTH-1:0] mag_a_p1;
   logic [MAG_WIDTH-1:0] mag_b_p1;
   logic [1:0]           dir_p1;
   logic [COL_W-1:0]     col_p1;
   logic [ROW_W-1:0]     row_p1;

   logic                 vld_p2;
   logic [MAG_WIDTH-1:0] mag_p2;
   logic [1:0]           dir_p2;
   logic                 done_p2;

   assign dir_c = bus.matrix_p22[MAG_WIDTH +: 2];
   assign mag_c = bus.matrix_p22[MAG_WIDTH-1:0];

   // Direction-to-pair mapping is fixed and independent of image geometry.
   always_comb begin
      mag_a = bus.matrix_p21[MAG_WIDTH-1:0];
      mag_b = bus.matrix_p23[MAG_WIDTH-1:0];
      case (dir_c)
         2'b00: begin
            mag_a = bus.matrix_p21[MAG_WIDTH-1:0];
            mag_b = bus.matrix_p23[MAG_WIDTH-1:0];
         end
         2'b01: begin
            mag_a = bus.matrix_p13[MAG_WIDTH-1:0];
            mag_b = bus.matrix_p31[MAG_WIDTH-1:0];
         end
         2'b10: begin
            mag_a = bus.matrix_p12[MAG_WIDTH-1:0];
            mag_b = bus.matrix_p32[MAG_WIDTH-1:0];
         end
         default: begin
            mag_a = bus.matrix_p11[MAG_WIDTH-1:0];
            mag_b = bus.matrix_p33[MAG_WIDTH-1:0];
         end
      endcase
   end

   // A window arriving with frame_start is the first pixel of the new frame.
   always_comb begin
      col_tag = bus.frame_start ? '0 : col_cnt;
      row_tag = bus.frame_start ? '0 : row_cnt;
      col_nxt = col_tag + 1'b1;
      row_nxt = row_tag;
      if (col_tag == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (row_tag == ROW_LAST) ? '0 : row_tag + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (bus.win_valid) begin
         col_cnt <= col_nxt;
         row_cnt <= row_nxt;
      end else if (bus.frame_start) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end
   end

   // ---- stage p1: capture centre, selected pair and position tag ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         mag_c_p1 <= '0;
         mag_a_p1 <= '0;
         mag_b_p1 <= '0;
         dir_p1   <= '0;
         col_p1   <= '0;
         row_p1   <= '0;
      end else begin
         vld_p1 <= bus.win_valid;
         if (bus.win_valid) begin
            mag_c_p1 <= mag_c;
            mag_a_p1 <= mag_a;
            mag_b_p1 <= mag_b;
            dir_p1   <= dir_c;
            col_p1   <= col_tag;
            row_p1   <= row_tag;
         end
      end
   end

   // ---- stage p2: suppression decision and border zeroing ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         mag_p2  <= '0;
         dir_p2  <= '0;
         done_p2 <= 1'b0;
      end else begin
         vld_p2  <= vld_p1;
         done_p2 <= vld_p1 && (col_p1 == COL_LAST) && (row_p1 == ROW_LAST);
         if (vld_p1) begin
            mag_p2 <= (nms_keep(mag_c_p1, mag_a_p1, mag_b_p1) && !on_border(col_p1, row_p1))
                      ? mag_c_p1 : '0;
            dir_p2 <= dir_p1;
         end
      end
   end

   assign bus.nms_valid  = vld_p2;
   assign bus.nms_mag    = mag_p2;
   assign bus.nms_dir    = dir_p2;
   assign bus.frame_done = done_p2;
endmodule
